// File: rtl/bc_result_tracker_pkg.sv
// bc_pkg: shared FSM state encoding, result codes and sample decoding helpers.
package bc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, STABLE = 2'd2, FAULT = 2'd3} state_t;
    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_GT   = 2'b01;
    localparam logic [1:0] CODE_EQ   = 2'b10;
    localparam logic [1:0] CODE_LT   = 2'b11;
    function automatic logic [1:0] encode(input logic gt, input logic eq, input logic lt);
        return gt ? CODE_GT : eq ? CODE_EQ : lt ? CODE_LT : CODE_NONE;
    endfunction
    function automatic logic is_legal(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt} inside {3'b100, 3'b010, 3'b001};
    endfunction
endpackage

// File: rtl/bc_result_tracker_if.sv
// bc_result_tracker_if: comparator sample inputs and tracker status outputs.
interface bc_result_tracker_if #(parameter int RUN_W = 4, parameter int CNT_W = 8);
    logic             clr;
    logic             in_valid;
    logic             in_gt;
    logic             in_eq;
    logic             in_lt;
    logic             stable;
    logic [1:0]       stable_code;
    logic             change;
    logic [RUN_W-1:0] run_len;
    logic [CNT_W-1:0] cnt_gt;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_lt;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             fault;
    modport master (
        output clr, in_valid, in_gt, in_eq, in_lt,
        input  stable, stable_code, change, run_len, cnt_gt, cnt_eq, cnt_lt, err, err_cnt, fault
    );
    modport slave (
        input  clr, in_valid, in_gt, in_eq, in_lt,
        output stable, stable_code, change, run_len, cnt_gt, cnt_eq, cnt_lt, err, err_cnt, fault
    );
endinterface

// File: rtl/bc_result_tracker_sat.sv
// sat_counter: up-counter that sticks at all-ones, with sync clear.
module sat_counter #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (clr) cnt_q <= '0;
        else if (inc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/bc_result_tracker.sv
// bc_result_tracker: checks one-hot comparator results, debounces them into a
// stable verdict and keeps saturating per-class and error statistics.
module bc_result_tracker
    import bc_pkg::*;
#(
    parameter int STABLE_N = 4,
    parameter int RUN_W    = 4,
    parameter int CNT_W    = 8
) (
    input logic                clk,
    input logic                rst,
    bc_result_tracker_if.slave bus
);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_THR = RUN_W'(STABLE_N);
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [1:0]       last_q, last_d, scode_q, scode_d, code;
    logic             change_q, change_d, err_q, err_d;
    logic             legal, take, same, enter;
    assign code  = encode(bus.in_gt, bus.in_eq, bus.in_lt);
    assign legal = is_legal(bus.in_gt, bus.in_eq, bus.in_lt);
    assign take  = bus.in_valid && !bus.clr && legal && state_q != FAULT;
    assign same  = code == last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            run_q    <= '0;
            last_q   <= CODE_NONE;
            scode_q  <= CODE_NONE;
            change_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            last_q   <= last_d;
            scode_q  <= scode_d;
            change_q <= change_d;
            err_q    <= err_d;
        end
    end
    // last_q is CODE_NONE in IDLE, so a first sample never counts as "same".
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        last_d  = last_q;
        if (bus.clr) begin
            state_d = IDLE;
            run_d   = '0;
            last_d  = CODE_NONE;
        end else if (bus.in_valid && !legal) begin
            state_d = FAULT;
        end else if (take) begin
            run_d   = !same ? RUN_W'(1) : run_q == RUN_MAX ? run_q : run_q + 1'b1;
            last_d  = code;
            state_d = run_d >= RUN_THR ? STABLE : TRACK;
        end
    end
    always_comb begin
        enter    = take && state_d == STABLE && (state_q != STABLE || !same);
        change_d = enter && code != scode_q;
        scode_d  = bus.clr ? CODE_NONE : change_d ? code : scode_q;
        err_d    = bus.in_valid && !bus.clr && !legal;
    end
    sat_counter #(.W(CNT_W)) u_cnt_gt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(take && code == CODE_GT), .cnt_o(bus.cnt_gt));
    sat_counter #(.W(CNT_W)) u_cnt_eq (.clk(clk), .rst(rst), .clr(bus.clr), .inc(take && code == CODE_EQ), .cnt_o(bus.cnt_eq));
    sat_counter #(.W(CNT_W)) u_cnt_lt (.clk(clk), .rst(rst), .clr(bus.clr), .inc(take && code == CODE_LT), .cnt_o(bus.cnt_lt));
    sat_counter #(.W(CNT_W)) u_cnt_er (.clk(clk), .rst(rst), .clr(bus.clr), .inc(err_d), .cnt_o(bus.err_cnt));
    assign bus.stable      = state_q == STABLE;
    assign bus.fault       = state_q == FAULT;
    assign bus.stable_code = scode_q;
    assign bus.change      = change_q;
    assign bus.err         = err_q;
    assign bus.run_len     = run_q;
endmodule
